// File: rtl/ternary_mm_host_driver_if.sv
// Host-side stream bundle for ternary_mm_host_driver: start/busy control,
// operand beat input stream and 16-bit result output stream.
interface ternary_mm_host_driver_if;
    logic        start;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_weights;
    logic [7:0]  in_act;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_last;

    modport master (
        output start, in_valid, in_weights, in_act, res_ready,
        input  busy, in_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  start, in_valid, in_weights, in_act, res_ready,
        output busy, in_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/ternary_mm_host_driver.sv
// Host-side initiator for one 1.58-bit matmul tile: clear, stream, drain, collect, emit.
// Optional stall counter built only when TERNARY_MM_HOST_DRIVER_PERF_EN is defined.
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | one cycle of tile_rst_n=0
//   STREAM  | accepting K_STEPS operand beats onto the tile pins
//   DRAIN   | DRAIN_CYCLES zero-input cycles while the tile finishes
//   COLLECT | sampling OUT_BYTES result bytes from tile_uo_out
//   EMIT    | presenting result words on the res stream
module ternary_mm_host_driver #(
    parameter int K_STEPS      = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int OUT_BYTES    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    ternary_mm_host_driver_if.slave    host,
    output logic [7:0]                 tile_ui_in,
    output logic [7:0]                 tile_uio_in,
    input  logic [7:0]                 tile_uo_out,
    output logic                       tile_ena,
    output logic                       tile_rst_n,
    output logic [15:0]                stall_cycles
);
    localparam int BEAT_W  = $clog2(K_STEPS + 1);
    localparam int BYTE_W  = $clog2(OUT_BYTES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int WORDS   = OUT_BYTES / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_COLLECT, S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]          byte_buf_q [OUT_BYTES];
    logic [7:0]          byte_buf_d [OUT_BYTES];
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                res_last_q, res_last_d;
    logic [15:0]         res_data_q, res_data_d;
    logic [7:0]          tile_ui_q, tile_ui_d;
    logic [7:0]          tile_uio_q, tile_uio_d;
    logic                tile_ena_q, tile_ena_d;
    logic                tile_rst_n_q, tile_rst_n_d;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        byte_buf_d   = byte_buf_q;
        tile_ui_d    = '0;
        tile_uio_d   = '0;
        res_data_d   = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    state_d    = S_CLEAR;
                    beat_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_CLEAR: state_d = S_STREAM;
            S_STREAM: begin
                if (host.in_valid && in_ready_q) begin
                    tile_ui_d  = host.in_weights;
                    tile_uio_d = host.in_act;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(K_STEPS - 1)) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d    = S_COLLECT;
                    byte_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            S_COLLECT: begin
                for (int i = 0; i < OUT_BYTES; i++) begin
                    if (byte_cnt_q == BYTE_W'(i)) byte_buf_d[i] = tile_uo_out;
                end
                // byte counter is reused as the word index once emitting
                if (byte_cnt_q == BYTE_W'(OUT_BYTES - 1)) begin
                    state_d    = S_EMIT;
                    byte_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (res_valid_q && host.res_ready) begin
                    if (byte_cnt_q == BYTE_W'(WORDS - 1)) state_d = S_IDLE;
                    else byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        in_ready_d   = (state_d == S_STREAM);
        tile_rst_n_d = (state_d != S_CLEAR);
        tile_ena_d   = 1'b1;
        res_valid_d  = (state_d == S_EMIT);
        res_last_d   = (state_d == S_EMIT) && (byte_cnt_d == BYTE_W'(WORDS - 1));
        if (state_d == S_EMIT) begin
            for (int j = 0; j < WORDS; j++) begin
                if (byte_cnt_d == BYTE_W'(j))
                    res_data_d = {byte_buf_d[2*j+1], byte_buf_d[2*j]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            for (int i = 0; i < OUT_BYTES; i++) byte_buf_q[i] <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            res_data_q   <= '0;
            tile_ui_q    <= '0;
            tile_uio_q   <= '0;
            tile_ena_q   <= 1'b0;
            tile_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            byte_buf_q   <= byte_buf_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            res_valid_q  <= res_valid_d;
            res_last_q   <= res_last_d;
            res_data_q   <= res_data_d;
            tile_ui_q    <= tile_ui_d;
            tile_uio_q   <= tile_uio_d;
            tile_ena_q   <= tile_ena_d;
            tile_rst_n_q <= tile_rst_n_d;
        end
    end

`ifdef TERNARY_MM_HOST_DRIVER_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && host.start) begin
            stall_d = '0;
        end else if (((state_q == S_STREAM && !host.in_valid) ||
                      (state_q == S_EMIT && res_valid_q && !host.res_ready)) &&
                     stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign host.busy      = busy_q;
    assign host.in_ready  = in_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;
    assign host.res_last  = res_last_q;
    assign tile_ui_in     = tile_ui_q;
    assign tile_uio_in    = tile_uio_q;
    assign tile_ena       = tile_ena_q;
    assign tile_rst_n     = tile_rst_n_q;
endmodule
